// File: rtl/alu_div_sequencer_pkg.sv
// rtl/alu_div_sequencer_pkg.sv - shared constants for the sequenced RV32M divider
//
// Purpose: state encoding for the divider FSM, the ALU function codes the
// divider drives onto the shared ALU, and RV32M funct3 decode constants.
// Ports: none (package).

package alu_div_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NEG_DVD = 3'd1,
    ST_NEG_DVS = 3'd2,
    ST_ITER    = 3'd3,
    ST_NEG_RES = 3'd4,
    ST_DONE    = 3'd5
  } div_state_e;

  // Shared ALU function select codes
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_XOR = 4'b0100;

  // RV32M funct3 encodings for the divide group
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // funct3 bit 0 clear means a signed op, bit 1 set means remainder
  function automatic logic f3_is_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  function automatic logic f3_want_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/alu_div_sequencer.sv
// rtl/alu_div_sequencer.sv - multi-cycle restoring divider driving the shared ALU
//
// Purpose: RV32M DIV/DIVU/REM/REMU. One ALU subtract per cycle; the ALU carry
// (1 = no borrow) forms one quotient bit per ITER cycle. Signed ops negate the
// operands before and the selected result after the 32 iterations, giving a
// fixed latency per op type.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, is_signed, want_rem request and op type, sampled only in IDLE
//   dividend, divisor          operands, captured at start
//   busy, done, div_by_zero    status; done is a one-cycle pulse
//   result                     quotient or remainder, held after done
//   alu_a, alu_b, alu_fn       operands/function driven onto the shared ALU
//   alu_r, alu_cf              combinational ALU result and carry

module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_fn,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf
);

  div_state_e state_q, state_d;

  logic [XLEN-1:0] dvd_q;     // dividend magnitude, shifts into the quotient
  logic [XLEN-1:0] dvs_q;     // divisor magnitude
  logic [XLEN-1:0] rem_q;     // partial remainder
  logic [4:0]      cnt_q;
  logic            is_signed_q;
  logic            want_rem_q;
  logic            sign_q_q;  // quotient must be negated
  logic            sign_r_q;  // remainder must be negated (follows dividend)
  logic            dbz_q;

  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] dvd_n;
  logic [XLEN-1:0] res_sel;
  logic            res_neg;

  // Restoring step: keep the difference when no borrow, else the shifted-in value.
  // The partial remainder after step k is < 2^k, so 32 bits never overflow.
  assign rem_n   = alu_cf ? alu_r : alu_a;
  assign dvd_n   = {dvd_q[XLEN-2:0], alu_cf};
  assign res_sel = want_rem_q ? rem_q : dvd_q;
  assign res_neg = want_rem_q ? sign_r_q : sign_q_q;

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_fn  = FN_ADD;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = ST_DONE;
          end else if (is_signed) begin
            state_d = ST_NEG_DVD;
          end else begin
            state_d = ST_ITER;
          end
        end
      end
      ST_NEG_DVD: begin
        alu_b   = dvd_q;
        alu_fn  = FN_SUB;
        state_d = ST_NEG_DVS;
      end
      ST_NEG_DVS: begin
        alu_b   = dvs_q;
        alu_fn  = FN_SUB;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        alu_a  = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
        alu_b  = dvs_q;
        alu_fn = FN_SUB;
        if (cnt_q == 5'd31) begin
          state_d = is_signed_q ? ST_NEG_RES : ST_DONE;
        end
      end
      ST_NEG_RES: begin
        alu_b   = res_sel;
        alu_fn  = FN_SUB;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      is_signed_q <= 1'b0;
      want_rem_q  <= 1'b0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dbz_q       <= 1'b0;
      result      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dvd_q       <= dividend;
            dvs_q       <= divisor;
            rem_q       <= '0;
            cnt_q       <= '0;
            is_signed_q <= is_signed;
            want_rem_q  <= want_rem;
            sign_q_q    <= dividend[XLEN-1] ^ divisor[XLEN-1];
            sign_r_q    <= dividend[XLEN-1];
            dbz_q       <= (divisor == '0);
            if (divisor == '0) begin
              result <= want_rem ? dividend : '1;
            end
          end
        end
        ST_NEG_DVD: begin
          if (dvd_q[XLEN-1]) dvd_q <= alu_r;
        end
        ST_NEG_DVS: begin
          if (dvs_q[XLEN-1]) dvs_q <= alu_r;
        end
        ST_ITER: begin
          rem_q <= rem_n;
          dvd_q <= dvd_n;
          cnt_q <= cnt_q + 5'd1;
          // Unsigned ops have no fix-up stage, so latch the result on the last step
          if (cnt_q == 5'd31 && !is_signed_q) begin
            result <= want_rem_q ? rem_n : dvd_n;
          end
        end
        ST_NEG_RES: begin
          result <= res_neg ? alu_r : res_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// tb/tb_alu_div_sequencer.sv - directed self-checking bench for alu_div_sequencer

module tb_alu_div_sequencer;
  import alu_div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        want_rem = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] result, alu_a, alu_b, alu_r;
  logic [3:0]  alu_fn;
  logic        alu_cf;
  logic [32:0] alu_sum;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Shared ALU model: add, or subtract as A + ~B + 1 with carry = no borrow
  always_comb begin
    alu_sum = '0;
    if (alu_fn == FN_SUB) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    else                  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  end
  assign alu_r  = alu_sum[31:0];
  assign alu_cf = alu_sum[32];

  alu_div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .want_rem(want_rem), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_r(alu_r), .alu_cf(alu_cf)
  );

  // Launch one op and observe it; lat = cycle of done relative to the start edge
  // (-1 on timeout). busy_ok clears if busy drops before done, or if busy/done
  // are still high the cycle after done.
  task automatic run_op(input logic s, input logic wr, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic [31:0] res,
                        output logic dbz, output logic busy_ok);
    lat = -1; res = '0; dbz = 1'b0; busy_ok = 1'b1;
    @(negedge clk);
    is_signed = s; want_rem = wr; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k; res = result; dbz = div_by_zero;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (busy || done) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      tests_failed++; $display("FAIL reset_status: got busy=%b done=%b dbz=%b expected 0 0 0", busy, done, div_by_zero);
    end
    tests_run++;
    if (result !== 32'h0) begin
      tests_failed++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    tests_run++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_fn !== FN_ADD) begin
      tests_failed++; $display("FAIL reset_alu: got a=%h b=%h fn=%h expected 0 0 %h", alu_a, alu_b, alu_fn, FN_ADD);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_divu();
    int lat; logic [31:0] res; logic dbz, bok;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, res, dbz, bok);
    tests_run++;
    if (lat != 33 || res !== 32'd14 || dbz !== 1'b0 || !bok) begin
      tests_failed++; $display("FAIL divu_100_7: got lat=%0d res=%h dbz=%b busy_ok=%b expected 33 0000000e 0 1", lat, res, dbz, bok);
    end
    tests_run++;
    if (alu_fn !== FN_ADD || alu_a !== 32'h0 || alu_b !== 32'h0) begin
      tests_failed++; $display("FAIL idle_alu_after_op: got a=%h b=%h fn=%h expected 0 0 %h", alu_a, alu_b, alu_fn, FN_ADD);
    end
    run_op(1'b0, 1'b1, 32'd100, 32'd7, lat, res, dbz, bok);
    tests_run++;
    if (lat != 33 || res !== 32'd2 || !bok) begin
      tests_failed++; $display("FAIL remu_100_7: got lat=%0d res=%h busy_ok=%b expected 33 00000002 1", lat, res, bok);
    end
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res; logic dbz, bok;
    run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, lat, res, dbz, bok);
    tests_run++;
    if (lat != 36 || res !== 32'hFFFFFFFD || !bok) begin
      tests_failed++; $display("FAIL div_m7_2: got lat=%0d res=%h busy_ok=%b expected 36 fffffffd 1", lat, res, bok);
    end
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat, res, dbz, bok);
    tests_run++;
    if (lat != 36 || res !== 32'hFFFFFFFF || !bok) begin
      tests_failed++; $display("FAIL rem_m7_2: got lat=%0d res=%h busy_ok=%b expected 36 ffffffff 1", lat, res, bok);
    end
  endtask

  task automatic test_div_by_zero();
    int lat; logic [31:0] res; logic dbz, bok;
    run_op(1'b0, 1'b0, 32'd5, 32'd0, lat, res, dbz, bok);
    tests_run++;
    if (lat != 1 || res !== 32'hFFFFFFFF || dbz !== 1'b1 || !bok) begin
      tests_failed++; $display("FAIL divu_5_0: got lat=%0d res=%h dbz=%b busy_ok=%b expected 1 ffffffff 1 1", lat, res, dbz, bok);
    end
    run_op(1'b1, 1'b1, 32'd5, 32'd0, lat, res, dbz, bok);
    tests_run++;
    if (lat != 1 || res !== 32'd5 || dbz !== 1'b1) begin
      tests_failed++; $display("FAIL rem_5_0: got lat=%0d res=%h dbz=%b expected 1 00000005 1", lat, res, dbz);
    end
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'd3, lat, res, dbz, bok);
    tests_run++;
    if (dbz !== 1'b0 || res !== 32'h0) begin
      tests_failed++; $display("FAIL dbz_clears: got dbz=%b res=%h expected 0 00000000", dbz, res);
    end
  endtask

  task automatic test_boundaries();
    int lat; logic [31:0] res; logic dbz, bok;
    logic        v_s[8];
    logic        v_r[8];
    logic [31:0] v_a[8];
    logic [31:0] v_b[8];
    logic [31:0] v_e[8];
    v_s = '{1, 1, 0, 0, 1, 1, 1, 0};
    v_r = '{0, 1, 0, 1, 0, 1, 1, 0};
    v_a = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFFFF};
    v_b = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hC0000000, 32'hC0000000,
            32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd1};
    v_e = '{32'h80000000, 32'h0, 32'd1, 32'h3FFFFFFF,
            32'hFFFFFFF2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      run_op(v_s[i], v_r[i], v_a[i], v_b[i], lat, res, dbz, bok);
      tests_run++;
      if (res !== v_e[i] || lat != (v_s[i] ? 36 : 33) || !bok) begin
        tests_failed++;
        $display("FAIL vector_%0d: got res=%h lat=%0d busy_ok=%b expected %h %0d 1",
                 i, res, lat, bok, v_e[i], v_s[i] ? 36 : 33);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat; int pulses;
    logic [31:0] res;
    lat = -1; pulses = 0; res = '0;
    @(negedge clk);
    is_signed = 1'b0; want_rem = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        start = 1'b1; is_signed = 1'b1; want_rem = 1'b1; dividend = 32'd9; divisor = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (lat < 0) begin lat = k; res = result; end
      end
      if (!busy && lat > 0) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    tests_run++;
    if (lat != 33 || res !== 32'd14 || pulses != 1) begin
      tests_failed++; $display("FAIL start_while_busy: got lat=%0d res=%h pulses=%0d expected 33 0000000e 1", lat, res, pulses);
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] res; logic dbz, bok;
    @(negedge clk);
    is_signed = 1'b1; want_rem = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL busy_before_reset: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_fn !== FN_ADD || result !== 32'h0) begin
      tests_failed++; $display("FAIL async_reset: got busy=%b done=%b fn=%h res=%h expected 0 0 %h 00000000", busy, done, alu_fn, result, FN_ADD);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, res, dbz, bok);
    tests_run++;
    if (lat != 33 || res !== 32'd14 || !bok) begin
      tests_failed++; $display("FAIL op_after_reset: got lat=%0d res=%h busy_ok=%b expected 33 0000000e 1", lat, res, bok);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_by_zero();
    test_boundaries();
    test_start_while_busy();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
